connect4_drop_ctrl: RTL and testbench

Piece-drop controller for the Connect-4 board. Accepts a player's column choice, tracks per-column fill height, runs a timed falling-piece animation for the display, then issues the one-shot column/row write that places the piece into the board/win-detection logic. It also alternates the active player after each placed piece. It sits between the input/debounce logic and the win checker, and drives the `colval`, `waddr` and `Player` lines that the win checker consumes.

---
 rtl/connect4_drop_ctrl.sv | 87 ++++++++
 tb/tb_connect4_drop_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_drop_ctrl.sv
// Connect-4 piece-drop controller: column heights, fall animation,
// one-shot column/row write to the win checker, player alternation.
module connect4_drop_ctrl #(
   parameter int DROP_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       drop_req,
   input  logic [2:0] col_sel,
   input  logic       game_over,
   output logic [2:0] colval,
   output logic [4:0] waddr,
   output logic       Player,
   output logic       busy,
   output logic [2:0] fall_row,
   output logic       drop_done,
   output logic       reject
);

   localparam int TW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
   localparam logic [TW-1:0] TMAX = TW'(DROP_TICKS - 1);

   typedef enum logic [1:0] {IDLE, FALL, SETCOL, WRITE} state_t;

   state_t        state, state_n;
   logic [2:0]    height [8];
   logic [2:0]    col;
   logic [2:0]    target;
   logic [TW-1:0] tick;
   logic          wrap;
   logic          accept;

   assign wrap   = (tick == TMAX);
   assign accept = (state == IDLE) && drop_req && (col_sel != 3'd7)
                   && (height[col_sel] < 3'd6) && !game_over;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = FALL;
         FALL:    if (wrap && fall_row == target) state_n = SETCOL;
         SETCOL:  state_n = WRITE;
         WRITE:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) height[i] <= 3'd0;
         col      <= 3'd0;
         target   <= 3'd0;
         tick     <= '0;
         fall_row <= 3'd0;
         Player   <= 1'b1;
         reject   <= 1'b0;
      end else begin
         reject <= drop_req && !accept;
         if (accept) begin
            col      <= col_sel;
            target   <= 3'd5 - height[col_sel];
            fall_row <= 3'd0;
            tick     <= '0;
         end
         if (state == FALL) begin
            tick <= wrap ? '0 : tick + TW'(1);
            if (wrap && fall_row != target) fall_row <= fall_row + 3'd1;
         end
         // Height and turn advance only once the write has been issued
         if (state == WRITE) begin
            height[col] <= height[col] + 3'd1;
            Player      <= ~Player;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign drop_done = (state == WRITE);
   assign colval    = (state == SETCOL) ? col : 3'd7;
   assign waddr     = (state == WRITE) ? 5'd11 + {target, 2'b00} : 5'd3;

endmodule

// File: tb/tb_connect4_drop_ctrl.sv
// Scoreboard bench for connect4_drop_ctrl: random and directed drops
// checked against a board-level model of heights, turns and timing.
module tb_connect4_drop_ctrl;

   localparam int T = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drop_req = 1'b0;
   logic [2:0] col_sel = 3'd0;
   logic       game_over = 1'b0;
   logic [2:0] colval;
   logic [4:0] waddr;
   logic       Player;
   logic       busy;
   logic [2:0] fall_row;
   logic       drop_done;
   logic       reject;

   connect4_drop_ctrl #(.DROP_TICKS(T)) dut (
      .clk(clk),
      .rst(rst),
      .drop_req(drop_req),
      .col_sel(col_sel),
      .game_over(game_over),
      .colval(colval),
      .waddr(waddr),
      .Player(Player),
      .busy(busy),
      .fall_row(fall_row),
      .drop_done(drop_done),
      .reject(reject)
   );

   always #5 clk = ~clk;

   typedef struct {
      int col;
      int wa;
      int pl;
      int len;
      int tgt;
   } drop_t;

   drop_t done_q[$];
   int    rej_q[$];
   int    errors = 0;
   int    checks = 0;
   int    edge_n = 0;
   int    h[7];
   int    pl = 1;
   int    free_edge = 0;
   int    n_acc = 0;

   always @(posedge clk) edge_n = edge_n + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: sampled 1 time unit after each active edge
   int         bcnt = 0;
   logic       pcv = 1'b0;
   logic [2:0] pcol = 3'd7;
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         bcnt = 0;
         pcv  = 1'b0;
      end else begin : mon
         drop_t d;
         int    k;
         logic  er;
         if (busy) begin
            if (done_q.size() == 0) chk("busy_unexpected", 1, 0);
            else begin
               k = bcnt / T;
               chk("fall_row", fall_row,
                   (k < done_q[0].tgt) ? k : done_q[0].tgt);
            end
            bcnt++;
         end
         if (drop_done || waddr != 5'd3) begin
            chk("write_window", {drop_done, waddr != 5'd3}, 2'b11);
            if (done_q.size() == 0) chk("write_unexpected", 1, 0);
            else begin
               d = done_q.pop_front();
               chk("waddr", waddr, d.wa);
               chk("write_player", Player, d.pl);
               chk("busy_len", bcnt, d.len);
               chk("colval_lead", pcv ? pcol : 3'd7, d.col);
            end
         end
         if (pcv && !drop_done) chk("colval_orphan", pcol, 7);
         if (!busy) bcnt = 0;
         pcv  = (colval != 3'd7);
         pcol = colval;
         er = (rej_q.size() > 0) && (rej_q[0] == edge_n);
         if (er) void'(rej_q.pop_front());
         if (er || reject) chk("reject", reject, er);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 7; i++) h[i] = 0;
      pl = 1;
      free_edge = 0;
      done_q.delete();
      rej_q.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      drop_req = 1'b0;
      model_reset();
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic req(input int c, input bit go);
      int    e;
      drop_t d;
      @(negedge clk);
      e = edge_n + 1;
      drop_req  = 1'b1;
      col_sel   = c[2:0];
      game_over = go;
      if (c <= 6 && h[c] < 6 && !go && e >= free_edge) begin
         d.col = c;
         d.tgt = 5 - h[c];
         d.wa  = 11 + 4 * d.tgt;
         d.pl  = pl;
         d.len = (d.tgt + 1) * T + 2;
         done_q.push_back(d);
         h[c]++;
         pl = 1 - pl;
         free_edge = e + d.len + 1;
         n_acc++;
      end else begin
         rej_q.push_back(e);
      end
      @(negedge clk);
      drop_req  = 1'b0;
      game_over = 1'b0;
   endtask

   task automatic wait_free();
      while (edge_n + 1 < free_edge) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag, input int exp_pl);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_colval"}, colval, 7);
      chk({tag, "_waddr"}, waddr, 3);
      chk({tag, "_player"}, Player, exp_pl);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset(2);
      check_idle("reset", 1);
      chk("reset_fall_row", fall_row, 0);
      chk("reset_done", drop_done, 0);
      chk("reset_reject", reject, 0);

      // First and second drop into column 3
      req(3, 1'b0);
      wait_free();
      chk("player_after_first", Player, 0);
      req(3, 1'b0);
      wait_free();
      chk("player_after_second", Player, 1);

      // Fill column 0, then one more
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         req(0, 1'b0);
         wait_free();
      end
      req(0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check_idle("full_col", pl);
      end

      // Illegal column, game over, request while busy
      req(7, 1'b0);
      req(2, 1'b1);
      req(4, 1'b0);
      repeat (3) @(negedge clk);
      req(5, 1'b0);
      wait_free();
      chk("player_after_blocked", Player, pl);

      // Reset during the fall
      do_reset(1);
      req(1, 1'b0);
      repeat (4) @(negedge clk);
      do_reset(1);
      check_idle("mid_reset", 1);
      req(1, 1'b0);
      wait_free();

      // Random game
      do_reset(1);
      n_acc = 0;
      for (int i = 0; i < 200 && n_acc < 20; i++) begin
         int c;
         bit go;
         c  = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
         go = ($urandom_range(0, 15) == 0);
         req(c, go);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_free();
      repeat (4) @(negedge clk);
      chk("random_drops", n_acc, 20);
      chk("done_q_drained", done_q.size(), 0);
      chk("rej_q_drained", rej_q.size(), 0);
      chk("final_player", Player, pl);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
